// File: rtl/tcm_loader_pkg.sv
// Shared types and sizing helpers for the TCM loader slice.
package tcm_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_WRITE,
    ST_VRD,
    ST_DONE
  } state_e;

  localparam int unsigned DEF_DATA_WIDTH = 32;

  function automatic int unsigned bytes_of(input int unsigned dw);
    return dw / 8;
  endfunction

  // Lane index needs at least one bit even for single-byte words.
  function automatic int unsigned lane_w_of(input int unsigned dw);
    return (dw / 8 > 1) ? $clog2(dw / 8) : 1;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs bytes little-endian into a word, tracking lane index and byte enables.
module byte_packer
  import tcm_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    push_i,
  input  logic                    last_i,
  input  logic [7:0]              byte_i,
  output logic [DATA_WIDTH-1:0]   word_o,
  output logic [DATA_WIDTH/8-1:0] be_o,
  output logic                    flush_o
);

  localparam int unsigned BYTES  = bytes_of(DATA_WIDTH);
  localparam int unsigned LANE_W = lane_w_of(DATA_WIDTH);

  logic [LANE_W-1:0]     lane_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic [BYTES-1:0]      be_q;
  logic                  word_full;

  assign word_full = (lane_q == LANE_W'(BYTES - 1));
  assign flush_o   = push_i && (word_full || last_i);

  // word_o/be_o already include the byte being pushed this cycle.
  always_comb begin
    word_o = word_q;
    be_o   = be_q;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (push_i && (lane_q == LANE_W'(i))) begin
        word_o[i*8 +: 8] = byte_i;
        be_o[i]          = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane_q <= '0;
      word_q <= '0;
      be_q   <= '0;
    end else if (clear_i || flush_o) begin
      lane_q <= '0;
      word_q <= '0;
      be_q   <= '0;
    end else if (push_i) begin
      lane_q <= lane_q + 1'b1;
      word_q <= word_o;
      be_q   <= be_o;
    end
  end

endmodule

// File: rtl/tcm_loader.sv
// Streams bytes into a TCM SRAM port as packed words; optional readback
// checksum pass when TCM_LOADER_VERIFY_EN is defined.
module tcm_loader
  import tcm_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned N_ENTRIES  = 1024,
  localparam int unsigned AW = $clog2(N_ENTRIES),
  localparam int unsigned LW = $clog2(N_ENTRIES * DATA_WIDTH / 8) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [AW-1:0]           base_addr_i,
  input  logic [LW-1:0]           len_i,
  input  logic [7:0]              s_data_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [DATA_WIDTH-1:0]   checksum_o,
  output logic                    err_o,
  output logic                    en_o,
  output logic                    we_o,
  output logic [DATA_WIDTH/8-1:0] be_o,
  output logic [AW-1:0]           addr_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic                    ready_i
);

  localparam int unsigned BYTES = bytes_of(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [LW-1:0]         len_q, byte_cnt_q;
  logic [AW-1:0]         wr_addr_q, addr_d;
  logic                  en_d, we_d;
  logic [BYTES-1:0]      be_d, pk_be;
  logic [DATA_WIDTH-1:0] data_d, pk_word;
  logic                  start_acc, accept, last_byte, bytes_left, pk_flush;

  assign start_acc  = (state_q == ST_IDLE) && start_i;
  assign accept     = (state_q == ST_FILL) && s_valid_i && s_ready_o;
  assign last_byte  = (LW'(byte_cnt_q + 1'b1) == len_q);
  assign bytes_left = (byte_cnt_q != len_q);

  byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (start_acc),
    .push_i  (accept),
    .last_i  (last_byte),
    .byte_i  (s_data_i),
    .word_o  (pk_word),
    .be_o    (pk_be),
    .flush_o (pk_flush)
  );

`ifdef TCM_LOADER_VERIFY_EN
  logic [AW-1:0]         base_q, rd_addr_q;
  logic [LW-1:0]         words, rd_issue_q, rsp_cnt_q;
  logic [DATA_WIDTH-1:0] rd_sum_q, rd_word_sum;
  logic                  issue_more, rsp_last;
  int unsigned           tail;

  assign words      = LW'((32'(len_q) + BYTES - 1) / BYTES);
  assign tail       = 32'(len_q) % BYTES;
  assign issue_more = (rd_issue_q != words);
  assign rsp_last   = (rsp_cnt_q == LW'(words - 1'b1));

  // Only the final word is trimmed to its filled lanes.
  always_comb begin
    rd_word_sum = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (!rsp_last || tail == 0 || i < tail) begin
        rd_word_sum = rd_word_sum + DATA_WIDTH'(data_i[i*8 +: 8]);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q     <= '0;
      rd_addr_q  <= '0;
      rd_issue_q <= '0;
      rsp_cnt_q  <= '0;
      rd_sum_q   <= '0;
      err_o      <= 1'b0;
    end else if (start_acc) begin
      base_q     <= base_addr_i;
      rsp_cnt_q  <= '0;
      rd_sum_q   <= '0;
      err_o      <= 1'b0;
    end else begin
      // The first read is issued on the WRITE->VRD edge from base_q.
      if (state_q == ST_WRITE) begin
        rd_addr_q  <= base_q + 1'b1;
        rd_issue_q <= LW'(1);
      end else if (state_q == ST_VRD && issue_more) begin
        rd_addr_q  <= rd_addr_q + 1'b1;
        rd_issue_q <= rd_issue_q + 1'b1;
      end
      if (state_q == ST_VRD && ready_i) begin
        rsp_cnt_q <= rsp_cnt_q + 1'b1;
        rd_sum_q  <= rd_sum_q + rd_word_sum;
        if (rsp_last) err_o <= ((rd_sum_q + rd_word_sum) != checksum_o);
      end
    end
  end
`else
  // Read-data ports are idle without the verify pass.
  assign err_o = 1'b0 & (ready_i | (^data_i));
`endif

  always_comb begin
    state_d = state_q;
    en_d    = 1'b0;
    we_d    = 1'b0;
    be_d    = '0;
    data_d  = '0;
    addr_d  = addr_o;
    case (state_q)
      ST_IDLE: if (start_i) state_d = (len_i == '0) ? ST_DONE : ST_FILL;
      ST_FILL: begin
        if (pk_flush) begin
          state_d = ST_WRITE;
          en_d    = 1'b1;
          we_d    = 1'b1;
          be_d    = pk_be;
          data_d  = pk_word;
          addr_d  = wr_addr_q;
        end
      end
      ST_WRITE: begin
        if (bytes_left) begin
          state_d = ST_FILL;
        end else begin
`ifdef TCM_LOADER_VERIFY_EN
          state_d = ST_VRD;
          en_d    = 1'b1;
          addr_d  = base_q;
`else
          state_d = ST_DONE;
`endif
        end
      end
      ST_VRD: begin
`ifdef TCM_LOADER_VERIFY_EN
        if (issue_more) begin
          en_d   = 1'b1;
          addr_d = rd_addr_q;
        end
        if (ready_i && rsp_last) state_d = ST_DONE;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      s_ready_o  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      en_o       <= 1'b0;
      we_o       <= 1'b0;
      be_o       <= '0;
      addr_o     <= '0;
      data_o     <= '0;
      checksum_o <= '0;
      len_q      <= '0;
      byte_cnt_q <= '0;
      wr_addr_q  <= '0;
    end else begin
      state_q   <= state_d;
      s_ready_o <= (state_d == ST_FILL);
      busy_o    <= (state_d != ST_IDLE);
      done_o    <= (state_d == ST_DONE);
      en_o      <= en_d;
      we_o      <= we_d;
      be_o      <= be_d;
      addr_o    <= addr_d;
      data_o    <= data_d;
      if (start_acc) begin
        len_q      <= len_i;
        byte_cnt_q <= '0;
        checksum_o <= '0;
        wr_addr_q  <= base_addr_i;
      end else begin
        if (accept) begin
          byte_cnt_q <= byte_cnt_q + 1'b1;
          checksum_o <= checksum_o + DATA_WIDTH'(s_data_i);
        end
        if (state_q == ST_WRITE) wr_addr_q <= wr_addr_q + 1'b1;
      end
    end
  end

endmodule
